// File: rtl/mask_encoder.sv
// Sequential bit-scanning encoder: accepts a mask and emits the binary index
// of each set bit, one per idx handshake, lowest-first or highest-first.
module mask_encoder #(
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 5,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_mask,
  input  logic             flush,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_last,
  output logic             done,
  output logic             busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pending, pending_nxt;
  logic             done_nxt;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_onehot;

  // Later matches overwrite earlier ones, so the scan direction picks the winner.
  function automatic logic [IDX_W-1:0] find_set(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] idx;
    int               b;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b = DESCEND ? i : (WIDTH - 1 - i);
      if (m[b]) idx = b[IDX_W-1:0];
    end
    return idx;
  endfunction

  always_comb begin
    sel_idx             = find_set(pending);
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  assign idx_out    = sel_idx;
  assign idx_valid  = (state == SCAN);
  assign busy       = (state == SCAN);
  assign idx_last   = (state == SCAN) && ((pending & (pending - 1'b1)) == '0);
  // The done cycle doubles as the mandatory bubble between masks.
  assign load_ready = (state == IDLE) && !done;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    if (flush) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            if (load_mask != '0) begin
              pending_nxt = load_mask;
              state_nxt   = SCAN;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        SCAN: begin
          if (idx_ready) begin
            pending_nxt = pending & ~sel_onehot;
            if (idx_last) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mask_encoder.sv
// Randomized bench for mask_encoder: ascending and descending instances share
// stimulus and are compared against index queues built from each mask.
module tb_mask_encoder;
  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic             flush = 1'b0;
  logic             idx_ready = 1'b0;
  logic [WIDTH-1:0] load_mask = '0;
  logic [1:0]       load_ready, idx_valid, idx_last, done, busy;
  logic [IDX_W-1:0] idx_out [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mask_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[0]),
    .load_mask(load_mask), .flush(flush), .idx_valid(idx_valid[0]),
    .idx_ready(idx_ready), .idx_out(idx_out[0]), .idx_last(idx_last[0]),
    .done(done[0]), .busy(busy[0])
  );

  mask_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .DESCEND(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[1]),
    .load_mask(load_mask), .flush(flush), .idx_valid(idx_valid[1]),
    .idx_ready(idx_ready), .idx_out(idx_out[1]), .idx_last(idx_last[1]),
    .done(done[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Load one mask and consume it; the expected index order is simply the set
  // bits of the mask listed upward (ascending) or downward (descending).
  task automatic run_mask(input logic [31:0] m, input int stall_pct, input int init_stall);
    int q0[$];
    int q1[$];
    int guard;
    bit rdy;
    for (int i = 0; i < WIDTH; i++)
      if (m[i]) begin
        q0.push_back(i);
        q1.push_front(i);
      end
    @(negedge clk);
    guard = 0;
    while (load_ready !== 2'b11 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("load_ready", load_ready, 2'b11);
    load_valid = 1'b1;
    load_mask  = m;
    @(posedge clk); #1;
    if (m == 32'h0) begin
      load_valid = 1'b0;
      @(negedge clk);
      chk("zero_done", done, 2'b11);
      chk("zero_valid", idx_valid, 2'b00);
      chk("zero_busy", busy, 2'b00);
      chk("zero_load_ready", load_ready, 2'b00);
    end else begin
      guard = 0;
      while (q0.size() > 0 && guard < 500) begin
        guard++;
        load_valid = 1'($urandom_range(1));
        load_mask  = $urandom;
        if (init_stall > 0) begin
          rdy = 1'b0;
          init_stall--;
        end else begin
          rdy = ($urandom_range(99) >= stall_pct);
        end
        idx_ready = rdy;
        @(negedge clk);
        chk("valid", idx_valid, 2'b11);
        chk("busy", busy, 2'b11);
        chk("done_in_scan", done, 2'b00);
        chk("load_ready_scan", load_ready, 2'b00);
        chk("idx_asc", idx_out[0], q0[0]);
        chk("idx_desc", idx_out[1], q1[0]);
        chk("last", idx_last, (q0.size() == 1) ? 2'b11 : 2'b00);
        @(posedge clk); #1;
        if (rdy) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
      end
      chk("scan_bound", q0.size(), 0);
      load_valid = 1'b0;
      idx_ready  = 1'b0;
      @(negedge clk);
      chk("done", done, 2'b11);
      chk("done_valid", idx_valid, 2'b00);
      chk("done_load_ready", load_ready, 2'b00);
    end
    @(negedge clk);
    chk("done_clear", done, 2'b00);
    chk("idle_load_ready", load_ready, 2'b11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] m;
    #1;
    chk("rst_load_ready", load_ready, 2'b11);
    chk("rst_valid", idx_valid, 2'b00);
    chk("rst_idx_asc", idx_out[0], 0);
    chk("rst_idx_desc", idx_out[1], 0);
    chk("rst_last", idx_last, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_busy", busy, 2'b00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run_mask(32'h8000_0011, 0, 0);
    run_mask(32'h0000_0C00, 0, 3);
    run_mask(32'h0000_0000, 0, 0);
    run_mask(32'hFFFF_FFFF, 0, 0);
    run_mask(32'h0000_0001, 0, 0);
    run_mask(32'h8000_0000, 20, 0);

    // flush with idx_ready on the fifth index
    @(negedge clk);
    load_valid = 1'b1;
    load_mask  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    load_valid = 1'b0;
    idx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_pre_idx", idx_out[0], i);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idx4", idx_out[0], 4);
    @(posedge clk); #1;
    flush     = 1'b0;
    idx_ready = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 2'b00);
    chk("flush_valid", idx_valid, 2'b00);
    chk("flush_done", done, 2'b00);
    chk("flush_idx_clear", idx_out[0], 0);
    @(negedge clk);
    chk("flush_done_later", done, 2'b00);

    // load offered during flush in IDLE is dropped
    @(posedge clk); #1;
    flush      = 1'b1;
    load_valid = 1'b1;
    load_mask  = 32'h0000_0005;
    @(posedge clk); #1;
    flush      = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop_busy", busy, 2'b00);
    chk("flush_drop_done", done, 2'b00);
    run_mask(32'h0000_0001, 0, 0);

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    load_valid = 1'b1;
    load_mask  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    load_valid = 1'b0;
    idx_ready  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre_rst_idx", idx_out[0], 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", idx_valid, 2'b00);
    chk("arst_busy", busy, 2'b00);
    idx_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_load_ready", load_ready, 2'b11);
    chk("post_rst_busy", busy, 2'b00);
    chk("post_rst_idx_asc", idx_out[0], 0);
    chk("post_rst_idx_desc", idx_out[1], 0);
    chk("post_rst_last", idx_last, 2'b00);
    chk("post_rst_done", done, 2'b00);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(3))
        0:       m = $urandom;
        1:       m = $urandom & $urandom & $urandom;
        2:       m = 32'h1 << $urandom_range(31);
        default: m = 32'h0;
      endcase
      run_mask(m, 30, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
